muldiv_unit: RTL

Iterative multiply/divide unit with HI/LO result registers, attached to the EX stage of the five-stage pipelined CPU alongside the ALU. It executes MULT, MULTU, DIV and DIVU over multiple cycles and raises a pipeline stall toward the hazard logic while busy. It can be aborted by the same flush that clears IF/ID on a taken branch or jump. Operand width is parametrised.

---
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the EX stage.
// Optional single-cycle multiplier when MULDIV_FAST_MUL_EN is defined.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             flush_i,
  input  logic             hilo_rd_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic             div0_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // state  | meaning
  // IDLE   | waiting for start_i, HI/LO stable
  // RUN    | one multiplier / quotient bit per cycle
  // FIX    | sign correction and HI/LO write
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [W2-1:0]    r_acc;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rs;
  logic             r_is_div;
  logic             r_div0;
  logic             r_qneg;
  logic             r_rneg;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_div0_flag;

  logic             w_accept;
  logic             w_rs_neg;
  logic             w_rt_neg;
  logic [WIDTH-1:0] w_rs_abs;
  logic [WIDTH-1:0] w_rt_abs;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH+1:0] w_trial;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic [W2-1:0]    w_mul_mag;
  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_accept = (r_state == S_IDLE) && start_i && !flush_i;
  assign w_rs_neg = ~op_i[0] & rs_i[WIDTH-1];
  assign w_rt_neg = ~op_i[0] & rt_i[WIDTH-1];
  assign w_rs_abs = w_rs_neg ? -rs_i : rs_i;
  assign w_rt_abs = w_rt_neg ? -rt_i : rt_i;

  assign w_mul_sum = {1'b0, r_acc[W2-1:WIDTH]} + {1'b0, (r_acc[0] ? r_a : {WIDTH{1'b0}})};

  // A borrow out of the trial subtraction means the divisor did not fit.
  assign w_trial = {r_rem, r_acc[WIDTH-1]};
  assign w_diff  = w_trial - {2'b00, r_b};
  assign w_ge    = ~w_diff[WIDTH+1];

`ifdef MULDIV_FAST_MUL_EN
  assign w_mul_mag = W2'(r_a) * W2'(r_b);
`else
  assign w_mul_mag = r_acc;
`endif
  assign w_prod = r_qneg ? -w_mul_mag : w_mul_mag;
  assign w_quo  = r_qneg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_rneg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rs        <= '0;
      r_is_div    <= 1'b0;
      r_div0      <= 1'b0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_done      <= 1'b0;
      r_div0_flag <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_div0_flag <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a      <= w_rs_abs;
            r_b      <= w_rt_abs;
            r_rs     <= rs_i;
            r_is_div <= op_i[1];
            r_div0   <= op_i[1] && (rt_i == '0);
            r_qneg   <= w_rs_neg ^ w_rt_neg;
            r_rneg   <= w_rs_neg;
            r_acc    <= {{WIDTH{1'b0}}, (op_i[1] ? w_rs_abs : w_rt_abs)};
            r_rem    <= '0;
            r_cnt    <= LAST_STEP;
`ifdef MULDIV_FAST_MUL_EN
            r_state  <= op_i[1] ? S_RUN : S_FIX;
`else
            r_state  <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else begin
            if (r_is_div) begin
              r_rem            <= w_ge ? w_diff[WIDTH:0] : w_trial[WIDTH:0];
              r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], w_ge};
            end else begin
              r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            end
            if (r_cnt == '0) r_state <= S_FIX;
            else             r_cnt   <= r_cnt - 1'b1;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          if (!flush_i) begin
            r_done      <= 1'b1;
            r_div0_flag <= r_div0;
            if (!r_is_div) begin
              {r_hi, r_lo} <= w_prod;
            end else if (r_div0) begin
              r_hi <= r_rs;
              r_lo <= '1;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o  = (r_state != S_IDLE);
  assign stall_o = busy_o & (hilo_rd_i | start_i);
  assign done_o  = r_done;
  assign div0_o  = r_div0_flag;
  assign hi_o    = r_hi;
  assign lo_o    = r_lo;

endmodule
